// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage access unit: access sizes, funct3 codes,
// controller states and the data-bus request/response bundles.
package mem_access_unit_pkg;

  localparam int unsigned XLEN_DEF = 64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } mem_fsm_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] addr;
    msize_t              size;
    logic [7:0]          strobe;
    logic [XLEN_DEF-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                addr_ok;
    logic                data_ok;
    logic [XLEN_DEF-1:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the memory-stage unit (master) and the memory side (slave).
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 64
) ();
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr;
  msize_t          dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_addr_ok;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational lane alignment: load extraction/extension, store strobe and
// data shifting, and natural-alignment check for the access size.
module mem_access_unit_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output msize_t          size,
  output logic            misaligned,
  output logic [XLEN-1:0] load_data,
  output logic [7:0]      strobe,
  output logic [XLEN-1:0] store_data
);
  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic            zext;

  assign size       = msize_t'(funct3[1:0]);
  assign zext       = funct3[2];
  assign shamt      = {offset, 3'b000};
  assign shifted    = rdata >> shamt;
  assign store_data = wdata << shamt;

  always_comb begin
    misaligned = 1'b0;
    strobe     = 8'h00;
    load_data  = '0;
    unique case (size)
      MSIZE1: begin
        strobe    = 8'h01 << offset;
        load_data = {{(XLEN-8){~zext & shifted[7]}}, shifted[7:0]};
      end
      MSIZE2: begin
        misaligned = offset[0];
        strobe     = 8'h03 << offset;
        load_data  = {{(XLEN-16){~zext & shifted[15]}}, shifted[15:0]};
      end
      MSIZE4: begin
        misaligned = |offset[1:0];
        strobe     = 8'h0F << offset;
        load_data  = {{(XLEN-32){~zext & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        misaligned = |offset;
        strobe     = 8'hFF << offset;
        load_data  = shifted;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues one data-bus transaction per load/store and
// holds the pipeline until the bus reports completion.
//
// state  | meaning
// IDLE   | no outstanding request; a new op issues combinationally
// ADDR   | request driven, waiting for addr_ok
// DATA   | request accepted, waiting for data_ok
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [2:0]         ex_funct3,
  input  logic [XLEN-1:0]    ex_addr,
  input  logic [XLEN-1:0]    ex_wdata,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic               csr_flush,
  mem_access_unit_if.master  dbus,
  output logic [XLEN-1:0]    mem_result,
  output logic               mem_done,
  output logic               handshake_stall,
  output logic               misalign
);
  mem_fsm_t        state, state_nxt;
  msize_t          a_size;
  logic            a_misaligned;
  logic [XLEN-1:0] a_load, a_sdata;
  logic [7:0]      a_strobe;
  logic            is_mem, misalign_cond, mem_op, issue, done;

  mem_access_unit_align #(.XLEN(XLEN)) u_mem_align (
    .funct3     (ex_funct3),
    .offset     (ex_addr[2:0]),
    .wdata      (ex_wdata),
    .rdata      (dbus.dresp_data),
    .size       (a_size),
    .misaligned (a_misaligned),
    .load_data  (a_load),
    .strobe     (a_strobe),
    .store_data (a_sdata)
  );

  assign is_mem        = ex_valid & (ex_mem_read | ex_mem_write);
  assign misalign_cond = is_mem & a_misaligned;
  assign mem_op        = is_mem & ~a_misaligned;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // A flush only blocks a fresh issue; an accepted transaction always runs to completion.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mem_op && !csr_flush) begin
          issue = 1'b1;
          if (dbus.dresp_addr_ok && dbus.dresp_data_ok) done = 1'b1;
          else if (dbus.dresp_addr_ok)                  state_nxt = S_DATA;
          else                                          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        issue = 1'b1;
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (dbus.dresp_data_ok) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  logic            o_valid, o_stall, o_done, o_misalign;
  logic [XLEN-1:0] o_addr, o_data, o_result;
  msize_t          o_size;
  logic [7:0]      o_strobe;

  // Request fields are zeroed outside a live request and everything is forced quiet under reset.
  always_comb begin
    o_valid    = issue;
    o_addr     = issue ? ex_addr : '0;
    o_size     = issue ? a_size : MSIZE1;
    o_strobe   = (issue && ex_mem_write) ? a_strobe : 8'h00;
    o_data     = (issue && ex_mem_write) ? a_sdata : '0;
    o_stall    = ((state != S_IDLE) || issue) && !done;
    o_done     = done;
    o_misalign = misalign_cond;
    if (misalign_cond)                o_result = ex_addr;
    else if (ex_valid && ex_mem_write) o_result = '0;
    else if (ex_valid && ex_mem_read)  o_result = a_load;
    else                              o_result = ex_alu_result;
    if (reset) begin
      o_valid    = 1'b0;
      o_addr     = '0;
      o_size     = MSIZE1;
      o_strobe   = 8'h00;
      o_data     = '0;
      o_stall    = 1'b0;
      o_done     = 1'b0;
      o_misalign = 1'b0;
      o_result   = '0;
    end
  end

  assign dbus.dreq_valid  = o_valid;
  assign dbus.dreq_addr   = o_addr;
  assign dbus.dreq_size   = o_size;
  assign dbus.dreq_strobe = o_strobe;
  assign dbus.dreq_data   = o_data;
  assign handshake_stall  = o_stall;
  assign mem_done         = o_done;
  assign misalign         = o_misalign;
  assign mem_result       = o_result;
endmodule
